// File: rtl/ex_pipe.sv
`default_nettype none
// =============================================================================
// ex_pipe : registered RV32 execute stage (ALU + optional iterative mul/div)
// Optional mul/div unit is built only when EX_PIPE_MULDIV_EN is defined.
// Revision: 1.0
// =============================================================================
module ex_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       inst_addr_i,
    input  logic [XLEN-1:0]   op1_i,
    input  logic [XLEN-1:0]   op2_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              rd_wen_i,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic              rd_wen_o,
    output logic              stall_o
);
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    // Debug-only address and the register fields the decoder does not use.
    logic unused_bits;
    assign unused_bits = ^{inst_addr_i, inst_i[24:15], inst_i[11:7]};

    logic            accept;
    logic            alu_fire;
    logic            alu_legal;
    logic [XLEN-1:0] alu_result;
    logic            is_mop;

    assign accept = valid_i && ready_o && !flush_i;

    always_comb begin
        alu_legal  = 1'b0;
        alu_result = '0;
        is_mop     = 1'b0;
        if (opcode == OPC_IMM) begin
            case (funct3)
                3'b000:  begin alu_result = op1_i + op2_i; alu_legal = 1'b1; end
                3'b100:  begin alu_result = op1_i ^ op2_i; alu_legal = 1'b1; end
                3'b110:  begin alu_result = op1_i | op2_i; alu_legal = 1'b1; end
                3'b111:  begin alu_result = op1_i & op2_i; alu_legal = 1'b1; end
                default: ;
            endcase
        end else if (opcode == OPC_REG && funct3 == 3'b000 && funct7 == F7_BASE) begin
            alu_result = op1_i + op2_i;
            alu_legal  = 1'b1;
        end else if (opcode == OPC_REG && funct3 == 3'b000 && funct7 == F7_SUB) begin
            alu_result = op1_i - op2_i;
            alu_legal  = 1'b1;
        end
`ifdef EX_PIPE_MULDIV_EN
        else if (opcode == OPC_REG && funct7 == 7'b0000001 &&
                 (funct3 == 3'b000 || funct3 == 3'b011 ||
                  funct3 == 3'b101 || funct3 == 3'b111)) begin
            is_mop = 1'b1;
        end
`endif
    end

`ifdef EX_PIPE_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [XLEN-1:0]   acc_hi, acc_lo, md_b;
    logic              md_div, md_sel_hi, md_wen;
    logic [REG_AW-1:0] md_rd;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    assign ready_o  = (state == IDLE);
    assign stall_o  = (state != IDLE);
    assign alu_fire = accept && !is_mop;

    // acc_hi:acc_lo is the running product for mul, remainder:quotient for div.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, md_b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: if (accept && is_mop) begin
                state_nxt = BUSY;
                count_nxt = '0;
            end
            BUSY: begin
                count_nxt = count + 1'b1;
                if (count == CNT_W'(XLEN - 1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            md_b      <= '0;
            md_div    <= 1'b0;
            md_sel_hi <= 1'b0;
            md_wen    <= 1'b0;
            md_rd     <= '0;
        end else if (accept && is_mop) begin
            acc_hi    <= '0;
            acc_lo    <= op1_i;
            md_b      <= op2_i;
            md_div    <= funct3[2];
            md_sel_hi <= funct3[1];
            md_wen    <= rd_wen_i;
            md_rd     <= rd_addr_i;
        end else if (state == BUSY) begin
            if (!md_div) begin
                acc_hi <= mul_sum[XLEN:1];
                acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
                acc_hi <= div_diff[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                acc_hi <= div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end
`else
    assign ready_o  = 1'b1;
    assign stall_o  = 1'b0;
    assign alu_fire = accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_o <= '0;
            rd_data_o <= '0;
            rd_wen_o  <= 1'b0;
        end else begin
            rd_wen_o <= 1'b0;
            if (alu_fire) begin
                rd_addr_o <= rd_addr_i;
                rd_data_o <= alu_result;
                rd_wen_o  <= rd_wen_i && alu_legal && (rd_addr_i != '0);
            end
`ifdef EX_PIPE_MULDIV_EN
            if (state == DONE && !flush_i) begin
                rd_addr_o <= md_rd;
                rd_data_o <= md_sel_hi ? acc_hi : acc_lo;
                rd_wen_o  <= md_wen && (md_rd != '0);
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_pipe.sv
`default_nettype none
// =============================================================================
// tb_ex_pipe : directed self-checking bench for ex_pipe
// Revision: 1.0
// =============================================================================
module tb_ex_pipe;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_wen_i = 1'b0;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        stall_o;

    int errors = 0;
    int checks = 0;

    ex_pipe #(.XLEN(XLEN), .REG_AW(5), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .flush_i(flush_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wen_o(rd_wen_o),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [6:0] opc);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        valid_i = 1'b1; inst_i = inst; op1_i = a; op2_i = b;
        rd_addr_i = rd; rd_wen_i = 1'b1;
        inst_addr_i = inst_addr_i + 32'd4;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_mop(input string tag, input logic [31:0] inst, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp);
        int busy_n = 0, stall_n = 0, wen_n = 0, wen_k = -1;
        logic [31:0] data_seen = '0;
        logic [4:0]  addr_seen = '0;
        issue(inst, a, b, rd);
        valid_i = 1'b0;
        for (int k = 0; k < XLEN + 6; k++) begin
            if (!ready_o) busy_n++;
            if (stall_o)  stall_n++;
            if (rd_wen_o) begin
                wen_n++; wen_k = k; data_seen = rd_data_o; addr_seen = rd_addr_o;
            end
            @(posedge clk); #1;
        end
        check({tag, " ready_low_cycles"}, busy_n, XLEN + 1);
        check({tag, " stall_cycles"}, stall_n, XLEN + 1);
        check({tag, " wen_pulses"}, wen_n, 1);
        check({tag, " wen_cycle"}, wen_k, XLEN + 1);
        check({tag, " data"}, data_seen, exp);
        check({tag, " addr"}, {27'd0, addr_seen}, {27'd0, rd});
    endtask

    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] REG = 7'b0110011;

    initial begin
        int wen_n;
        // Reset state
        #12;
        check("reset rd_addr", {27'd0, rd_addr_o}, 32'd0);
        check("reset rd_data", rd_data_o, 32'd0);
        check("reset rd_wen", {31'd0, rd_wen_o}, 32'd0);
        check("reset stall", {31'd0, stall_o}, 32'd0);
        check("reset ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // ADDI then an idle cycle
        issue(enc(7'd0, 3'b000, IMM), 32'd5, 32'd7, 5'd3);
        check("addi data", rd_data_o, 32'd12);
        check("addi addr", {27'd0, rd_addr_o}, 32'd3);
        check("addi wen", {31'd0, rd_wen_o}, 32'd1);
        idle_cycle();
        check("addi wen drop", {31'd0, rd_wen_o}, 32'd0);

        // Back-to-back ALU ops, one result per cycle
        issue(enc(7'b0100000, 3'b000, REG), 32'd10, 32'd3, 5'd4);
        check("sub 10-3", rd_data_o, 32'd7);
        check("sub 10-3 wen", {31'd0, rd_wen_o}, 32'd1);
        issue(enc(7'b0100000, 3'b000, REG), 32'd3, 32'd10, 5'd5);
        check("sub 3-10", rd_data_o, 32'hFFFF_FFF9);
        check("sub 3-10 wen", {31'd0, rd_wen_o}, 32'd1);
        issue(enc(7'd0, 3'b111, IMM), 32'h0000_F0F0, 32'h0000_00FF, 5'd6);
        check("andi", rd_data_o, 32'h0000_00F0);
        check("andi addr", {27'd0, rd_addr_o}, 32'd6);

        // Flush in IDLE blocks acceptance
        flush_i = 1'b1;
        issue(enc(7'd0, 3'b000, IMM), 32'd1, 32'd1, 5'd7);
        flush_i = 1'b0;
        check("idle flush wen", {31'd0, rd_wen_o}, 32'd0);
        check("idle flush addr", {27'd0, rd_addr_o}, 32'd6);

        issue(enc(7'd0, 3'b100, IMM), 32'h0000_FF00, 32'h0000_0FF0, 5'd8);
        check("xori", rd_data_o, 32'h0000_F0F0);
        issue(enc(7'd0, 3'b110, IMM), 32'h0000_F000, 32'h0000_000F, 5'd9);
        check("ori", rd_data_o, 32'h0000_F00F);
        issue(enc(7'd0, 3'b000, REG), 32'hFFFF_FFFF, 32'd2, 5'd10);
        check("add wrap", rd_data_o, 32'd1);
        check("add wrap wen", {31'd0, rd_wen_o}, 32'd1);
        issue(enc(7'd0, 3'b000, REG), 32'd4, 32'd4, 5'd0);
        check("x0 wen", {31'd0, rd_wen_o}, 32'd0);
        issue(enc(7'd0, 3'b000, 7'b0110111), 32'd4, 32'd4, 5'd5);
        check("illegal wen", {31'd0, rd_wen_o}, 32'd0);
        issue(enc(7'd0, 3'b001, IMM), 32'd4, 32'd4, 5'd5);
        check("illegal f3 wen", {31'd0, rd_wen_o}, 32'd0);
        valid_i = 1'b1; inst_i = enc(7'd0, 3'b000, IMM); rd_addr_i = 5'd5; rd_wen_i = 1'b0;
        @(posedge clk); #1;
        check("decoder wen low", {31'd0, rd_wen_o}, 32'd0);
        idle_cycle();

`ifdef EX_PIPE_MULDIV_EN
        run_mop("mul", enc(7'b0000001, 3'b000, REG), 32'h0001_0000, 32'h0001_0000, 5'd11, 32'd0);
        run_mop("mulhu", enc(7'b0000001, 3'b011, REG), 32'h0001_0000, 32'h0001_0000, 5'd12, 32'd1);
        run_mop("mul small", enc(7'b0000001, 3'b000, REG), 32'd123, 32'd45, 5'd13, 32'd5535);
        run_mop("divu", enc(7'b0000001, 3'b101, REG), 32'd100, 32'd7, 5'd14, 32'd14);
        run_mop("remu", enc(7'b0000001, 3'b111, REG), 32'd100, 32'd7, 5'd15, 32'd2);
        run_mop("divu0", enc(7'b0000001, 3'b101, REG), 32'h1234, 32'd0, 5'd16, 32'hFFFF_FFFF);
        run_mop("remu0", enc(7'b0000001, 3'b111, REG), 32'h1234, 32'd0, 5'd17, 32'h1234);

        // Flush at BUSY cycle 10
        issue(enc(7'b0000001, 3'b101, REG), 32'd100, 32'd7, 5'd18);
        valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("busy before flush", {31'd0, stall_o}, 32'd1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush ready", {31'd0, ready_o}, 32'd1);
        check("flush stall", {31'd0, stall_o}, 32'd0);
        check("flush wen", {31'd0, rd_wen_o}, 32'd0);
        issue(enc(7'd0, 3'b000, IMM), 32'd1, 32'd1, 5'd8);
        check("post-flush addi", rd_data_o, 32'd2);
        check("post-flush addi wen", {31'd0, rd_wen_o}, 32'd1);
        valid_i = 1'b0;
        wen_n = 0;
        for (int k = 0; k < XLEN + 4; k++) begin
            @(posedge clk); #1;
            if (rd_wen_o) wen_n++;
        end
        check("flush no writeback", wen_n, 0);

        // Reset during BUSY
        issue(enc(7'b0000001, 3'b000, REG), 32'd3, 32'd3, 5'd19);
        valid_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
`else
        issue(enc(7'b0000001, 3'b000, REG), 32'd3, 32'd3, 5'd9);
        check("mul disabled wen", {31'd0, rd_wen_o}, 32'd0);
        check("mul disabled ready", {31'd0, ready_o}, 32'd1);
        check("mul disabled stall", {31'd0, stall_o}, 32'd0);
        issue(enc(7'd0, 3'b000, IMM), 32'd1, 32'd1, 5'd8);
        check("pre-reset addi", rd_data_o, 32'd2);
        valid_i = 1'b0;
`endif
        #2 rst = 1'b0;
        #1;
        check("async rst data", rd_data_o, 32'd0);
        check("async rst addr", {27'd0, rd_addr_o}, 32'd0);
        check("async rst wen", {31'd0, rd_wen_o}, 32'd0);
        check("async rst stall", {31'd0, stall_o}, 32'd0);
        check("async rst ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk); rst = 1'b1;
        wen_n = 0;
        for (int k = 0; k < XLEN + 4; k++) begin
            @(posedge clk); #1;
            if (rd_wen_o) wen_n++;
        end
        check("post-reset no writeback", wen_n, 0);
        check("post-reset ready", {31'd0, ready_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/ex_pipe.md
Name: ex_pipe

Overview:
- Parametrised, registered execute stage for the RV32 core; successor to the single-cycle combinational execute block.
- Sits between id_ex and the register-file write port.
- Adds AND/OR/XOR immediate forms and a correctly ordered SUB.
- Adds an iterative multiply/divide unit (MUL, MULHU, DIVU, REMU) with a valid/ready handshake and a stall output to the pipeline control.

Parameters:
- XLEN, 32, datapath width. Must be a power of two, at least 8.
- REG_AW, 5, register address width.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  id_ex presents an instruction this cycle.
- ready_o  out  1  stage can accept; transfer occurs when valid_i && ready_o.
- flush_i  in  1  synchronous kill of any in-flight operation.
- inst_i  in  32  instruction word.
- inst_addr_i  in  32  instruction address; unused except for debug.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value or sign-extended immediate.
- rd_addr_i  in  REG_AW  destination register.
- rd_wen_i  in  1  decoder write enable.
- rd_addr_o  out  REG_AW  registered write-back address.
- rd_data_o  out  XLEN  registered write-back data.
- rd_wen_o  out  1  registered write strobe; high for exactly one cycle per result.
- stall_o  out  1  high while a mul/div is in progress.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, counter=0.
  - rd_addr_o=0, rd_data_o=0, rd_wen_o=0, stall_o=0, ready_o=1.
  - An operation in flight when reset asserts is discarded; no write-back follows reset release.
- Decode, from inst_i:
  - opcode 0010011, funct3 000/100/110/111: ADDI/XORI/ORI/ANDI, computed as op1 op op2.
  - opcode 0110011, funct7 0000000, funct3 000: ADD.
  - opcode 0110011, funct7 0100000, funct3 000: SUB = op1_i - op2_i.
  - opcode 0110011, funct7 0000001, funct3 000/011/101/111: MUL/MULHU/DIVU/REMU.
  - Any other encoding is accepted but produces rd_wen_o=0 the next cycle.
- Arithmetic: all results are modulo 2^XLEN. MULHU returns the upper XLEN bits of the unsigned 2*XLEN-bit product.
- State machine, IDLE / BUSY / DONE:
  - IDLE: ready_o=1.
    - On transfer of an ALU op: outputs register the result at that edge, so latency is 1 cycle; rd_wen_o = rd_wen_i && legal.
    - On transfer of a M-op: latch operands, rd_addr and op; go to BUSY with counter=0. rd_wen_o=0 next cycle.
  - BUSY: ready_o=0, stall_o=1. One shift-add (MUL/MULHU) or one restoring-divide step (DIVU/REMU) per cycle; counter increments. After XLEN steps, go to DONE.
  - DONE: write back rd_data_o/rd_addr_o with rd_wen_o=1 for one cycle; return to IDLE. ready_o=0 and stall_o=1 during DONE.
- M-op latency: transfer at edge N gives rd_wen_o=1 in the cycle after edge N+XLEN+1.
- Divide by zero: DIVU result is all-ones; REMU result is the dividend. The full XLEN-cycle latency is kept (no early exit).
- op1=0 or op2=0 on MUL: full latency, result 0.
- Back-to-back ALU ops: one result per cycle, no bubbles.
- flush_i:
  - While BUSY or DONE: return to IDLE next edge, rd_wen_o=0, no write-back.
  - In IDLE: the instruction presented that cycle is not accepted.
  - flush_i has priority over valid_i.
- valid_i while ready_o=0: ignored. Upstream must hold its instruction.
- x0: rd_wen_o is forced to 0 when rd_addr is 0.

Optional Feature:
- Macro: EX_PIPE_MULDIV_EN.
- Defined: mul/div unit, BUSY/DONE states and counter are present, as described above.
- Undefined:
  - No mul/div logic is built; stall_o is tied 0 and ready_o is tied 1.
  - funct7 0000001 encodings are treated as illegal: rd_wen_o=0 after 1 cycle.

Test Plan:
- Reset then ADDI, op1=5, op2=7, rd=3 -> next cycle rd_data_o=12, rd_addr_o=3, rd_wen_o=1; the following cycle rd_wen_o=0.
- SUB op1=10, op2=3 -> 7. SUB op1=3, op2=10 -> 0xFFFFFFF9. ANDI 0xF0F0 & 0x0FF -> 0xF0. Issue back-to-back, expecting one result per cycle.
- MUL 0x00010000*0x00010000 -> 0x00000000. MULHU same operands -> 0x00000001.
  - ready_o=0 and stall_o=1 for XLEN+1 cycles.
  - rd_wen_o pulses exactly once, at cycle N+XLEN+2.
- DIVU 100/7 -> 14. REMU 100/7 -> 2. DIVU 0x1234/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234.
- Start DIVU, assert flush_i at BUSY cycle 10 -> IDLE next edge, no rd_wen_o. A following ADDI 1+1 -> 2 one cycle later.
- Start MUL, drop rst at BUSY cycle 5 -> all outputs 0 immediately; after release, no write-back and ready_o=1.
